// File: rtl/reed_solomon_decoder_syndrome.sv
// Reed-Solomon syndrome generator: Horner evaluation of the received polynomial
// at alpha^0..alpha^(NUM_SYNDROMES-1) over GF(2^8), primitive polynomial 0x11D.
module reed_solomon_decoder_syndrome #(
  parameter int CODEWORD_LEN  = 255,
  parameter int NUM_SYNDROMES = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 deq_data,
  input  logic                       not_empty,
  output logic                       deq_en,
  output logic [8*NUM_SYNDROMES-1:0] syndromes,
  output logic                       syn_valid,
  input  logic                       syn_ready,
  output logic                       error_detected,
  output logic [15:0]                cw_count
);
  // state | meaning
  // ACCUM | folding accepted bytes into the syndrome registers
  // HOLD  | complete codeword result presented, waiting for syn_ready
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [7:0] LAST_IDX = 8'(CODEWORD_LEN - 1);

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
  endfunction

  // Shift-and-add product; with a constant b this reduces to an XOR network.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = gf_xtime(sh);
    end
    return acc;
  endfunction

  function automatic logic [7:0] alpha_pow(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < n; i++) r = gf_xtime(r);
    return r;
  endfunction

  state_t     state;
  logic [7:0] byte_cnt;
  logic [7:0] syn_q    [NUM_SYNDROMES];
  logic [7:0] syn_next [NUM_SYNDROMES];
  logic       last_byte;

  assign deq_en    = (state == ACCUM) && not_empty && !reset;
  assign last_byte = (byte_cnt == LAST_IDX);

  for (genvar j = 0; j < NUM_SYNDROMES; j++) begin : g_syn
    localparam logic [7:0] ROOT = alpha_pow(j);
    assign syn_next[j]          = gf_mul(syn_q[j], ROOT) ^ deq_data;
    assign syndromes[8*j +: 8]  = syn_q[j];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ACCUM;
      byte_cnt <= '0;
      cw_count <= '0;
      for (int j = 0; j < NUM_SYNDROMES; j++) syn_q[j] <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (deq_en) begin
            for (int j = 0; j < NUM_SYNDROMES; j++) syn_q[j] <= syn_next[j];
            if (last_byte) begin
              byte_cnt <= '0;
              state    <= HOLD;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
            end
          end
        end
        HOLD: begin
          if (syn_ready) begin
            for (int j = 0; j < NUM_SYNDROMES; j++) syn_q[j] <= '0;
            cw_count <= cw_count + 16'd1;
            state    <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign syn_valid      = (state == HOLD);
  assign error_detected = syn_valid && (|syndromes);

endmodule

// File: tb/tb_reed_solomon_decoder_syndrome.sv
// Scoreboard bench for the syndrome generator: an upstream FIFO model feeds bytes,
// expected syndromes come from direct (non-Horner) polynomial evaluation.
module tb_reed_solomon_decoder_syndrome;
  localparam int N  = 255;
  localparam int NS = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      deq_data;
  logic            not_empty;
  logic            deq_en;
  logic [8*NS-1:0] syndromes;
  logic            syn_valid;
  logic            syn_ready;
  logic            error_detected;
  logic [15:0]     cw_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0]      exp_t [255];
  logic [7:0]      log_t [256];
  logic [7:0]      fifo_q [$];
  logic [8*NS-1:0] exp_q  [$];
  logic [8*NS-1:0] last_syn;
  int              pops;
  int              acc_idx;
  int              exp_cw;

  always #5 clk = ~clk;

  reed_solomon_decoder_syndrome #(.CODEWORD_LEN(N), .NUM_SYNDROMES(NS)) dut (
    .clk(clk), .reset(reset), .deq_data(deq_data), .not_empty(not_empty),
    .deq_en(deq_en), .syndromes(syndromes), .syn_valid(syn_valid),
    .syn_ready(syn_ready), .error_detected(error_detected), .cw_count(cw_count)
  );

  function automatic logic [7:0] mul_ref(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[(int'(log_t[a]) + int'(log_t[b])) % 255];
  endfunction

  task automatic push_codeword(input logic [7:0] cw [N]);
    logic [8*NS-1:0] s;
    s = '0;
    for (int k = 0; k < N; k++) begin
      fifo_q.push_back(cw[k]);
      for (int j = 0; j < NS; j++)
        s[8*j +: 8] = s[8*j +: 8] ^ mul_ref(cw[k], exp_t[(j * (N - 1 - k)) % 255]);
    end
    exp_q.push_back(s);
  endtask

  // Drives the FIFO model and compares every presented result against the scoreboard.
  task automatic run_stream(input int max_cycles, input int ne_pct, input int hold_cycles);
    int   cyc, wait_cnt;
    logic exp_valid_next, chk_cw, gate;
    cyc = 0; wait_cnt = 0; exp_valid_next = 1'b0; chk_cw = 1'b0;
    while ((exp_q.size() > 0 || fifo_q.size() > 0 || chk_cw) && cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      gate      = ($urandom_range(99) < ne_pct);
      not_empty = (fifo_q.size() > 0) && gate;
      deq_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
      syn_ready = (wait_cnt >= hold_cycles);
      #1;
      checks++;
      if (deq_en !== (not_empty && !syn_valid)) begin
        failures++;
        $display("FAIL deq_en: got %b expected %b (syn_valid=%b)", deq_en, not_empty && !syn_valid, syn_valid);
      end
      if (chk_cw) begin
        checks++;
        if (cw_count !== 16'(exp_cw)) begin
          failures++;
          $display("FAIL cw_count: got %0d expected %0d", cw_count, exp_cw);
        end
        chk_cw = 1'b0;
      end
      if (exp_valid_next) begin
        checks++;
        if (syn_valid !== 1'b1) begin
          failures++;
          $display("FAIL latency: syn_valid got %b expected 1 after last byte", syn_valid);
        end
        exp_valid_next = 1'b0;
      end else if (syn_valid === 1'b1 && wait_cnt == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_valid: syn_valid got 1 expected 0");
      end
      if (syn_valid === 1'b1 && exp_q.size() > 0) begin
        checks++;
        if (syndromes !== exp_q[0]) begin
          failures++;
          $display("FAIL syndromes: got %h expected %h", syndromes, exp_q[0]);
        end
        checks++;
        if (error_detected !== (|exp_q[0])) begin
          failures++;
          $display("FAIL error_detected: got %b expected %b", error_detected, |exp_q[0]);
        end
        if (wait_cnt == 0) last_syn = syndromes;
        wait_cnt++;
        if (syn_ready) begin
          void'(exp_q.pop_front());
          exp_cw++;
          chk_cw   = 1'b1;
          wait_cnt = 0;
        end
      end else begin
        checks++;
        if (error_detected !== 1'b0 || syn_valid === 1'b1) begin
          failures++;
          $display("FAIL idle_outputs: error_detected=%b syn_valid=%b expected 0/0", error_detected, syn_valid);
        end
      end
      if (deq_en === 1'b1) begin
        void'(fifo_q.pop_front());
        pops++;
        if (acc_idx == N - 1) begin
          acc_idx = 0;
          exp_valid_next = 1'b1;
        end else begin
          acc_idx++;
        end
      end
    end
    not_empty = 1'b0;
    syn_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || fifo_q.size() != 0) begin
      failures++;
      $display("FAIL timeout: results pending %0d bytes pending %0d expected 0/0", exp_q.size(), fifo_q.size());
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; not_empty = 1'b1; deq_data = 8'hAA; syn_ready = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      checks++;
      if (deq_en !== 1'b0) begin
        failures++;
        $display("FAIL reset_deq_en: got %b expected 0", deq_en);
      end
    end
    @(negedge clk);
    reset = 1'b0; not_empty = 1'b0;
    #1;
    checks++;
    if (syn_valid !== 1'b0 || error_detected !== 1'b0 || syndromes !== '0 || cw_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: valid=%b err=%b syn=%h cw=%0d expected all zero",
               syn_valid, error_detected, syndromes, cw_count);
    end
    fifo_q.delete(); exp_q.delete();
    acc_idx = 0; exp_cw = 0;
  endtask

  task automatic test_zero_codeword;
    logic [7:0] cw [N];
    for (int k = 0; k < N; k++) cw[k] = 8'h00;
    pops = 0;
    push_codeword(cw);
    run_stream(1000, 100, 0);
    checks++;
    if (pops != N || last_syn !== '0 || cw_count !== 16'd1) begin
      failures++;
      $display("FAIL zero_codeword: pops=%0d syn=%h cw=%0d expected %0d/0/1", pops, last_syn, cw_count, N);
    end
  endtask

  task automatic test_last_byte_one;
    logic [7:0]      cw [N];
    logic [8*NS-1:0] ones;
    for (int k = 0; k < N; k++) cw[k] = 8'h00;
    cw[N-1] = 8'h01;
    for (int j = 0; j < NS; j++) ones[8*j +: 8] = 8'h01;
    push_codeword(cw);
    run_stream(1000, 100, 0);
    checks++;
    if (last_syn !== ones) begin
      failures++;
      $display("FAIL last_byte_one: got %h expected %h", last_syn, ones);
    end
  endtask

  task automatic test_first_byte_one;
    logic [7:0] cw [N];
    for (int k = 0; k < N; k++) cw[k] = 8'h00;
    cw[0] = 8'h01;
    push_codeword(cw);
    run_stream(1000, 100, 0);
    checks++;
    if (last_syn[7:0] !== 8'h01 || last_syn[15:8] !== 8'h8E) begin
      failures++;
      $display("FAIL first_byte_one: S0=%h S1=%h expected 01 8e", last_syn[7:0], last_syn[15:8]);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] cw [N];
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < N; k++) cw[k] = 8'($urandom_range(255));
      push_codeword(cw);
    end
    run_stream(2000, 100, 10);
  endtask

  task automatic test_random_not_empty;
    logic [7:0] cw [N];
    for (int k = 0; k < N; k++) cw[k] = 8'h00;
    pops = 0;
    push_codeword(cw);
    run_stream(5000, 50, 0);
    checks++;
    if (pops != N || last_syn !== '0) begin
      failures++;
      $display("FAIL random_not_empty: pops=%0d syn=%h expected %0d/0", pops, last_syn, N);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] cw [N];
    pops = 0;
    for (int k = 0; k < 100; k++) fifo_q.push_back(8'($urandom_range(1, 255)));
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      not_empty = 1'b1; deq_data = fifo_q[0];
      #1;
      if (deq_en === 1'b1) begin
        void'(fifo_q.pop_front());
        pops++;
      end
    end
    checks++;
    if (pops != 100) begin
      failures++;
      $display("FAIL partial_pops: got %0d expected 100", pops);
    end
    @(negedge clk);
    reset = 1'b1; not_empty = 1'b1; deq_data = 8'h55;
    #1;
    checks++;
    if (deq_en !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_deq_en: got %b expected 0", deq_en);
    end
    @(negedge clk);
    reset = 1'b0; not_empty = 1'b0;
    fifo_q.delete(); exp_q.delete();
    acc_idx = 0; exp_cw = 0;
    for (int k = 0; k < N; k++) cw[k] = 8'h00;
    push_codeword(cw);
    run_stream(1000, 100, 0);
    checks++;
    if (last_syn !== '0 || cw_count !== 16'd1) begin
      failures++;
      $display("FAIL reset_mid: syn=%h cw=%0d expected 0/1", last_syn, cw_count);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] cw [N];
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < N; k++) cw[k] = 8'($urandom_range(255));
      push_codeword(cw);
    end
    run_stream(5000, 80, 0);
    checks++;
    if (cw_count !== 16'd4) begin
      failures++;
      $display("FAIL back_to_back_count: got %0d expected 4", cw_count);
    end
  endtask

  initial begin
    logic [7:0] x;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = 8'(i);
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    reset = 1'b1; not_empty = 1'b0; deq_data = 8'h00; syn_ready = 1'b0;
    pops = 0; acc_idx = 0; exp_cw = 0; last_syn = '0;
    test_reset();
    test_zero_codeword();
    test_last_byte_one();
    test_first_byte_one();
    test_backpressure();
    test_random_not_empty();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reed_solomon_decoder_syndrome.md
REED_SOLOMON_DECODER_SYNDROME -- requirements
Module: reed_solomon_decoder_syndrome

Interface
REQ-001 Parameter: CODEWORD_LEN, 255, codeword length in bytes (2..255).
REQ-002 Parameter: NUM_SYNDROMES, 32, syndromes computed, 2t (1..32).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 deq_data  input  8  received byte at the upstream byte FIFO head, valid when not_empty=1.
REQ-006 not_empty  input  1  upstream FIFO holds at least one byte.
REQ-007 deq_en  output  1  pop request to the upstream FIFO.
REQ-008 syndromes  output  8*NUM_SYNDROMES  S_j in bits [8*j +: 8], j=0..NUM_SYNDROMES-1.
REQ-009 syn_valid  output  1  syndromes holds a complete codeword result.
REQ-010 syn_ready  input  1  downstream accepts the result.
REQ-011 error_detected  output  1  OR-reduction of all syndrome bits, qualified by syn_valid.
REQ-012 cw_count  output  16  completed codewords handed off, wraps at 2^16.

Function
REQ-013 Arithmetic in GF(2^8), primitive polynomial 0x11D, alpha = 0x02; addition is XOR.
REQ-014 Syndrome roots alpha^0..alpha^(NUM_SYNDROMES-1) (first consecutive root 0).
REQ-015 Bytes arrive highest-degree coefficient first: byte 0 of a codeword is r_(CODEWORD_LEN-1).
REQ-016 Two states: ACCUM and HOLD; state after reset is ACCUM.
REQ-017 deq_en = (state==ACCUM) AND not_empty AND NOT reset, combinational; a byte is accepted on any cycle with deq_en=1.
REQ-018 Per accepted byte b, every j updates in the same cycle: S_j <= (S_j * alpha^j) XOR b (Horner); constant multipliers are combinational, no lookup RAM.
REQ-019 Byte counter byte_cnt (8 bits) increments per accepted byte; in ACCUM with not_empty=0, all state holds.
REQ-020 Accepting the byte when byte_cnt == CODEWORD_LEN-1: syndromes take the final update, byte_cnt <= 0, state <= HOLD.
REQ-021 syn_valid = 1 exactly when state==HOLD; first asserted the cycle after the last byte is accepted (latency 1).
REQ-022 In HOLD: deq_en=0, syndromes and error_detected stable until handshake.
REQ-023 Handshake on syn_valid AND syn_ready: all S_j <= 0, cw_count increments, state <= ACCUM; first byte of the next codeword can be accepted the following cycle (one bubble cycle per codeword).
REQ-024 syn_ready in ACCUM is ignored.
REQ-025 error_detected = 0 whenever syn_valid = 0.
REQ-026 No partial-codeword flush: a codeword completes only after CODEWORD_LEN accepted bytes.

Reset
REQ-027 reset=1 on a clock edge: S_j=0 for all j, byte_cnt=0, cw_count=0, state=ACCUM; outputs next cycle: syn_valid=0, error_detected=0, syndromes=0.
REQ-028 deq_en=0 in any cycle with reset=1; no byte is consumed.
REQ-029 Reset mid-codeword or in HOLD discards the partial/pending result; the next accepted byte is byte 0 of a new codeword.

Verification
REQ-030 255 zero bytes, not_empty held 1, syn_ready=1 -> syn_valid one cycle after byte 254, all syndromes 0x00, error_detected=0, cw_count=1.
REQ-031 Bytes 0..253 = 0x00, byte 254 = 0x01 -> every S_j = 0x01, error_detected=1.
REQ-032 Byte 0 = 0x01, rest 0x00 -> S_0=0x01, S_1=0x8E (alpha^254), S_j = alpha^(254*j mod 255).
REQ-033 syn_ready=0 for 10 cycles after syn_valid, not_empty=1 -> deq_en=0 throughout, syndromes unchanged; handshake cycle +1 -> deq_en=1.
REQ-034 not_empty toggled randomly across one all-zero codeword -> exactly 255 pops, same result as REQ-030; accepted-byte count checked against FIFO pops.
REQ-035 reset for 1 cycle after 100 bytes, then 255 zero bytes -> single codeword, all syndromes 0x00, cw_count=1.
